// File: rtl/weight_buf_pkg.sv
// Shared defaults and helpers for the ping-pong weight buffer.
// Holds the default kernel geometry, the derived word count per bank and
// the index widths that follow from it.
package weight_buf_pkg;

    localparam int unsigned CH_DEF    = 3;
    localparam int unsigned K_DEF     = 5;
    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned OW_DEF    = 20;
    localparam int unsigned TOTAL_DEF = CH_DEF * K_DEF * K_DEF;
    localparam int unsigned IDX_W_DEF = $clog2(TOTAL_DEF);
    localparam int unsigned ROW_W_DEF = $clog2(K_DEF);

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_bank.sv
// One bank of kernel weights.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (read register only)
//   we        - write strobe; wdata is stored at linear index waddr
//   waddr     - linear index ch*K*K + row*K + col
//   wdata     - signed weight word
//   re        - read strobe; captures row rrow of every channel into rdata
//   rrow      - kernel row index
//   rdata     - registered row, lane ch*K+col sign-extended to OW bits
module weight_bank
    import weight_buf_pkg::*;
#(
    parameter int unsigned CH = CH_DEF,
    parameter int unsigned K  = K_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned OW = OW_DEF,
    localparam int unsigned TOTAL = CH * K * K,
    localparam int unsigned IDX_W = clog2_min1(TOTAL),
    localparam int unsigned ROW_W = clog2_min1(K)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [DW-1:0]        wdata,
    input  logic                 re,
    input  logic [ROW_W-1:0]     rrow,
    output logic [CH*K*OW-1:0]   rdata
);

    logic signed [DW-1:0] mem [TOTAL];
    logic [CH*K*OW-1:0]   row_d;

    // Storage is deliberately not reset; the owner's full flag says whether it is live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        row_d = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            for (int unsigned col = 0; col < K; col++) begin
                row_d[(c*K+col)*OW +: OW] =
                    OW'(mem[IDX_W'(c*K*K + 32'(rrow)*K + col)]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= row_d;
        end
    end

endmodule

// File: rtl/weight_pp_buffer.sv
// Ping-pong kernel weight buffer: one bank loads from a valid/ready stream
// while the other is read row by row by the consumer.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   s_valid/s_ready - load handshake, s_data is the weight word
//   load_abort      - drop the partially loaded bank and restart at index 0
//   kernel_valid    - read bank holds a complete kernel
//   kernel_release  - consumer is done with the read bank ("release" is a
//                     reserved word, hence the longer name)
//   rd_en, rd_row   - row read request
//   rd_valid        - one-cycle pulse, rd_data holds the completed read
//   rd_data         - lane ch*K+col at [(ch*K+col)*OW +: OW]
module weight_pp_buffer
    import weight_buf_pkg::*;
#(
    parameter int unsigned CH = CH_DEF,
    parameter int unsigned K  = K_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned OW = OW_DEF,
    localparam int unsigned TOTAL = CH * K * K,
    localparam int unsigned IDX_W = clog2_min1(TOTAL),
    localparam int unsigned ROW_W = clog2_min1(K)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic                 load_abort,
    output logic                 kernel_valid,
    input  logic                 kernel_release,
    input  logic                 rd_en,
    input  logic [ROW_W-1:0]     rd_row,
    output logic                 rd_valid,
    output logic [CH*K*OW-1:0]   rd_data
);

    logic [1:0]       full_q, full_d;
    logic             wb_q, wb_d;
    logic             rb_q, rb_d;
    logic [IDX_W-1:0] wcnt_q, wcnt_d;
    logic             rd_valid_q;
    logic             rd_sel_q;

    logic             accept;
    logic             last_word;
    logic             rel_fire;
    logic             rd_fire;
    logic [1:0]       bank_we;
    logic [1:0]       bank_re;
    logic [CH*K*OW-1:0] bank_rdata [2];

    assign s_ready      = !full_q[wb_q];
    assign kernel_valid = full_q[rb_q];

    // An abort wins over a coincident word: the word is neither stored nor counted.
    assign accept    = s_valid && s_ready && !load_abort;
    assign last_word = accept && (wcnt_q == IDX_W'(TOTAL - 1));
    assign rel_fire  = kernel_release && full_q[rb_q];
    assign rd_fire   = rd_en && full_q[rb_q] && (32'(rd_row) < K);

    // A fill always targets an empty bank and a release a full one, so when both
    // fire in one cycle they touch different flags.
    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        wcnt_d = wcnt_q;
        if (load_abort) begin
            wcnt_d = '0;
        end else if (accept) begin
            if (last_word) begin
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
                wcnt_d       = '0;
            end else begin
                wcnt_d = wcnt_q + IDX_W'(1);
            end
        end
        if (rel_fire) begin
            full_d[rb_q] = 1'b0;
            rb_d         = !rb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wcnt_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            full_q     <= full_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wcnt_q     <= wcnt_d;
            rd_valid_q <= rd_fire;
            // Remember which bank produced the row so a coincident release cannot redirect it.
            if (rd_fire) begin
                rd_sel_q <= rb_q;
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        assign bank_we[i] = accept && (wb_q == 1'(i));
        assign bank_re[i] = rd_fire && (rb_q == 1'(i));

        weight_bank #(
            .CH (CH),
            .K  (K),
            .DW (DW),
            .OW (OW)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we[i]),
            .waddr (wcnt_q),
            .wdata (s_data),
            .re    (bank_re[i]),
            .rrow  (rd_row),
            .rdata (bank_rdata[i])
        );
    end

    // Each bank holds its last row, so the selected bank's output is also the held value.
    assign rd_valid = rd_valid_q;
    assign rd_data  = bank_rdata[rd_sel_q];

endmodule

// File: tb/tb_weight_pp_buffer.sv
module tb_weight_pp_buffer;

    localparam int unsigned CH    = 3;
    localparam int unsigned K     = 5;
    localparam int unsigned DW    = 16;
    localparam int unsigned OW    = 20;
    localparam int unsigned TOTAL = CH * K * K;
    localparam int unsigned RDW   = CH * K * OW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  s_data = '0;
    logic           load_abort = 1'b0;
    logic           kernel_valid;
    logic           kernel_release = 1'b0;
    logic           rd_en = 1'b0;
    logic [2:0]     rd_row = '0;
    logic           rd_valid;
    logic [RDW-1:0] rd_data;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0]  mdl [2][TOTAL];
    logic [1:0]     mfull = '0;
    logic           mwb = 1'b0;
    logic           mrb = 1'b0;
    logic [6:0]     mcnt = '0;
    logic [RDW-1:0] m_hold = '0;
    logic           exp_rv = 1'b0;
    logic [RDW-1:0] exp_q [$];

    always #5 clk = ~clk;

    weight_pp_buffer #(
        .CH (CH),
        .K  (K),
        .DW (DW),
        .OW (OW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .load_abort     (load_abort),
        .kernel_valid   (kernel_valid),
        .kernel_release (kernel_release),
        .rd_en          (rd_en),
        .rd_row         (rd_row),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data)
    );

    task automatic chk(input string tag, input logic [RDW-1:0] obs, input logic [RDW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, RDW'(obs), RDW'(exp));
    endtask

    task automatic chk_lane(input string tag, input int lane, input logic [OW-1:0] exp);
        chk(tag, RDW'(rd_data[lane*OW +: OW]), RDW'(exp));
    endtask

    function automatic logic [RDW-1:0] exp_row(input logic b, input int r);
        logic [RDW-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            for (int col = 0; col < K; col++) begin
                v[(c*K+col)*OW +: OW] = OW'($signed(mdl[b][7'(c*K*K + r*K + col)]));
            end
        end
        return v;
    endfunction

    // One clock: check combinational outputs, advance the model, cross the edge,
    // then check the registered read outputs.
    task automatic tick();
        logic acc, rel, rdf;
        #1;
        if (!rst) begin
            chk1("s_ready", s_ready, !mfull[mwb]);
            chk1("kernel_valid", kernel_valid, mfull[mrb]);
        end
        acc = s_valid && !mfull[mwb] && !load_abort;
        rel = kernel_release && mfull[mrb];
        rdf = rd_en && mfull[mrb] && (32'(rd_row) < K);
        if (rst) begin
            mfull  = '0;
            mwb    = 1'b0;
            mrb    = 1'b0;
            mcnt   = '0;
            m_hold = '0;
            exp_rv = 1'b0;
            exp_q.delete();
        end else begin
            if (rdf) exp_q.push_back(exp_row(mrb, int'(rd_row)));
            exp_rv = rdf;
            if (load_abort) begin
                mcnt = '0;
            end else if (acc) begin
                mdl[mwb][mcnt] = s_data;
                if (mcnt == 7'(TOTAL - 1)) begin
                    mfull[mwb] = 1'b1;
                    mwb        = !mwb;
                    mcnt       = '0;
                end else begin
                    mcnt = mcnt + 7'd1;
                end
            end
            if (rel) begin
                mfull[mrb] = 1'b0;
                mrb        = !mrb;
            end
        end
        @(negedge clk);
        chk1("rd_valid", rd_valid, exp_rv);
        if (rd_valid) begin
            chk1("rd_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) m_hold = exp_q.pop_front();
        end
        chk("rd_data", rd_data, m_hold);
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(first + i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic rd(input int r);
        rd_en  = 1'b1;
        rd_row = 3'(r);
        tick();
        rd_en  = 1'b0;
    endtask

    task automatic rel_tick();
        kernel_release = 1'b1;
        tick();
        kernel_release = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk1("rst_s_ready", s_ready, 1'b1);
        chk1("rst_kernel_valid", kernel_valid, 1'b0);
        @(negedge clk);

        // Basic load 0..74 and row read
        load(0, 74);
        chk1("kv_before_last", kernel_valid, 1'b0);
        load(74, 1);
        chk1("kv_after_last", kernel_valid, 1'b1);
        rd(2);
        chk1("row2_valid", rd_valid, 1'b1);
        chk_lane("row2_ch1_col3", 1*K+3, 20'd38);
        chk_lane("row2_ch2_col4", 2*K+4, 20'd64);
        rd(5);
        chk1("bad_row_valid", rd_valid, 1'b0);
        chk_lane("bad_row_hold", 1*K+3, 20'd38);
        rel_tick();
        chk1("released_kv", kernel_valid, 1'b0);

        // Sign extension
        load(32'h8001, 1);
        load(32'h7fff, 1);
        load(300, 73);
        rd(0);
        chk_lane("sext_neg", 0, 20'hF8001);
        chk_lane("sext_pos", 1, 20'h07FFF);
        rel_tick();

        // Stream 160 words with no release: stalls after 150
        w = 0;
        for (int cyc = 0; cyc < 160; cyc++) begin
            s_valid = 1'b1;
            s_data  = DW'(w);
            if (!mfull[mwb]) w++;
            tick();
        end
        chk1("stall_s_ready", s_ready, 1'b0);
        chk1("stall_kv", kernel_valid, 1'b1);
        s_valid = 1'b0;
        rel_tick();
        chk1("after_rel_s_ready", s_ready, 1'b1);
        chk1("after_rel_kv", kernel_valid, 1'b1);
        for (int r = 0; r < 5; r++) begin
            rd(r);
            if (r == 0) chk_lane("bank1_row0_lane0", 0, 20'd75);
        end
        chk_lane("bank1_row4_ch2_col4", 2*K+4, 20'd149);
        rel_tick();
        rel_tick();
        chk1("empty_kv", kernel_valid, 1'b0);

        // Release coincident with the last word of the other bank
        load(0, 75);
        load(200, 74);
        s_valid        = 1'b1;
        s_data         = DW'(274);
        kernel_release = 1'b1;
        tick();
        s_valid        = 1'b0;
        kernel_release = 1'b0;
        #1;
        chk1("coinc_kv", kernel_valid, 1'b1);
        chk1("coinc_s_ready", s_ready, 1'b1);
        @(negedge clk);
        rd(0);
        chk_lane("coinc_row0_lane0", 0, 20'd200);
        // Read and release together: the row still comes from the released bank
        rd_en          = 1'b1;
        rd_row         = 3'd1;
        kernel_release = 1'b1;
        tick();
        rd_en          = 1'b0;
        kernel_release = 1'b0;
        chk_lane("rd_rel_row1_lane0", 0, 20'd205);

        // Abort mid-load, with a word presented in the abort cycle
        load(500, 40);
        s_valid    = 1'b1;
        s_data     = DW'(999);
        load_abort = 1'b1;
        tick();
        s_valid    = 1'b0;
        load_abort = 1'b0;
        load(100, 75);
        rd(0);
        chk_lane("abort_row0_lane0", 0, 20'd100);
        for (int r = 1; r < 5; r++) rd(r);
        rel_tick();

        // Reset mid-operation with a full bank and a partial load
        load(0, 75);
        load(600, 30);
        chk1("pre_rst_kv", kernel_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk1("mid_rst_kv", kernel_valid, 1'b0);
        chk1("mid_rst_rd_valid", rd_valid, 1'b0);
        chk("mid_rst_rd_data", rd_data, '0);
        chk1("mid_rst_s_ready", s_ready, 1'b1);
        @(negedge clk);
        rd(0);
        chk1("post_rst_rd_valid", rd_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
